// File: rtl/uart_pad_rx_if.sv
// Receive-side bundle of the pad UART: decoded byte, its strobes and the busy flag.
// The receiver drives it through `master`; a consumer reads it through `slave`.
interface uart_pad_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_frame_err,
    input rx_busy
  );
endinterface

// File: rtl/uart_pad_rx.sv
// 8N1 serial receiver for an asynchronous pad input.
// It synchronises the line into clk, mid-bit samples each frame and strobes out every byte.
module uart_pad_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 rx_pad_in,
  uart_pad_rx_if.master        rx_if
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   s;
  logic                   sample;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_pad_in};
  assign s      = sync_q[SYNC_STAGES-1];
  assign sample = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!s) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end

      StStart: begin
        if (sample) begin
          // A line already high again at mid-start is a glitch, not a frame.
          if (s) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            cnt_d     = FullLoad;
            bit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StData: begin
        if (sample) begin
          shift_d   = {s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = FullLoad;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StStop: begin
        if (sample) begin
          if (s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StWaitHigh: begin
        // A held-low break must not be re-read as a stream of start bits.
        if (s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sync_q    <= '1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_if.rx_data      = data_q;
  assign rx_if.rx_valid     = valid_q;
  assign rx_if.rx_frame_err = err_q;
  assign rx_if.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_pad_rx.sv
// Scoreboard bench for uart_pad_rx: default instance (16 clk/bit, 2 sync stages) and a
// minimum-period instance (4 clk/bit, 3 sync stages), each with its own expected-strobe queue.
module tb_uart_pad_rx;

  logic    clk = 1'b0;
  logic    reset_;
  logic    pad_a;
  logic    pad_b;
  int      checks   = 0;
  int      failures = 0;
  longint  cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_pad_rx_if rx_a ();
  uart_pad_rx_if rx_b ();

  uart_pad_rx #(
    .CLKS_PER_BIT (16),
    .SYNC_STAGES  (2)
  ) u_dut_a (
    .clk       (clk),
    .reset_    (reset_),
    .rx_pad_in (pad_a),
    .rx_if     (rx_a)
  );

  uart_pad_rx #(
    .CLKS_PER_BIT (4),
    .SYNC_STAGES  (3)
  ) u_dut_b (
    .clk       (clk),
    .reset_    (reset_),
    .rx_pad_in (pad_b),
    .rx_if     (rx_b)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     edge_n;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest pending expectation.
  task automatic mon_step(input bit which, input logic v, input logic e, input logic [7:0] d,
                          input logic busy);
    exp_t x;
    int   n;
    if (v === 1'b1 || e === 1'b1) begin
      chk("strobe_exclusive", longint'(v & e), 0);
      chk("busy_at_strobe", longint'(busy), longint'(e));
      n = which ? q_b.size() : q_a.size();
      if (n == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe dut=%0d actual valid=%0b err=%0b required none (edge %0d)",
                 which, v, e, cyc);
      end else begin
        if (which) x = q_b.pop_front();
        else       x = q_a.pop_front();
        chk("strobe_kind", longint'(e), longint'(x.is_err));
        chk("strobe_data", longint'(d), longint'(x.data));
        chk("strobe_edge", cyc, x.edge_n);
      end
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    mon_step(1'b0, rx_a.rx_valid, rx_a.rx_frame_err, rx_a.rx_data, rx_a.rx_busy);
    mon_step(1'b1, rx_b.rx_valid, rx_b.rx_frame_err, rx_b.rx_data, rx_b.rx_busy);
  end

  task automatic drive(input bit which, input logic v);
    if (which) pad_b = v;
    else       pad_a = v;
  endtask

  // Called and returns at a falling edge; the next rising edge is t0.
  task automatic send(input bit which, input int cpb, input int sync, input logic [7:0] b,
                      input logic stop, input logic [7:0] prev);
    exp_t       x;
    logic [9:0] fr;
    fr       = {stop, b, 1'b0};
    x.is_err = !stop;
    x.data   = stop ? b : prev;
    x.edge_n = cyc + 1 + sync + cpb / 2 + 9 * cpb;
    if (which) q_b.push_back(x);
    else       q_a.push_back(x);
    for (int i = 0; i < 10; i++) begin
      drive(which, fr[i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_a"},  longint'(rx_a.rx_data), 0);
    chk({tag, "_valid_a"}, longint'(rx_a.rx_valid), 0);
    chk({tag, "_err_a"},   longint'(rx_a.rx_frame_err), 0);
    chk({tag, "_busy_a"},  longint'(rx_a.rx_busy), 0);
  endtask

  initial begin
    int         busy_cnt;
    logic [9:0] fr;
    reset_ = 1'b0;
    pad_a  = 1'b1;
    pad_b  = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_data_b", longint'(rx_b.rx_data), 0);
    chk("reset_busy_b", longint'(rx_b.rx_busy), 0);
    reset_ = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte
    send(1'b0, 16, 2, 8'hA5, 1'b1, 8'h00);
    repeat (20) @(negedge clk);
    chk("single_data", longint'(rx_a.rx_data), 'hA5);
    chk("single_idle", longint'(rx_a.rx_busy), 0);

    // Glitch rejection: 4-cycle low pulse
    busy_cnt = 0;
    pad_a    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) pad_a = 1'b1;
      @(negedge clk);
      if (rx_a.rx_busy === 1'b1) busy_cnt++;
    end
    chk("glitch_busy_cycles", busy_cnt, 8);
    chk("glitch_data_kept", longint'(rx_a.rx_data), 'hA5);

    // Framing error then a long break
    send(1'b0, 16, 2, 8'h3C, 1'b0, 8'hA5);
    pad_a = 1'b0;
    repeat (200) @(negedge clk);
    chk("break_busy", longint'(rx_a.rx_busy), 1);
    repeat (200) @(negedge clk);
    pad_a = 1'b1;
    repeat (30) @(negedge clk);
    chk("break_data_kept", longint'(rx_a.rx_data), 'hA5);
    chk("break_released", longint'(rx_a.rx_busy), 0);

    // Back-to-back frames, no idle between
    send(1'b0, 16, 2, 8'h00, 1'b1, 8'hA5);
    send(1'b0, 16, 2, 8'hFF, 1'b1, 8'h00);
    send(1'b0, 16, 2, 8'h81, 1'b1, 8'hFF);
    repeat (30) @(negedge clk);
    chk("b2b_last_data", longint'(rx_a.rx_data), 'h81);

    // Reset during data bit 4 of 0x55; the rest of that frame is never sent
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 5; i++) begin
      pad_a = fr[i];
      repeat (16) @(negedge clk);
    end
    pad_a = fr[5];
    repeat (8) @(negedge clk);
    reset_ = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    pad_a  = 1'b1;
    repeat (40) @(negedge clk);
    chk_reset_outputs("midreset");
    send(1'b0, 16, 2, 8'h96, 1'b1, 8'h00);
    repeat (30) @(negedge clk);
    chk("after_reset_data", longint'(rx_a.rx_data), 'h96);

    // Minimum bit period instance
    send(1'b1, 4, 3, 8'h01, 1'b1, 8'h00);
    repeat (6) @(negedge clk);
    send(1'b1, 4, 3, 8'h80, 1'b1, 8'h01);
    repeat (20) @(negedge clk);
    chk("min_last_data", longint'(rx_b.rx_data), 'h80);

    repeat (20) @(negedge clk);
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
